// File: rtl/int_to_fp_convert_arbiter.sv
// Round-robin arbiter sharing one int32 -> recoded-f32 converter among
// NUM_REQ requesters. Fixed-latency pipeline (no bubble compression), one
// tagged response channel with valid/ready, and a wrapping completion count.
module int_to_fp_convert_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = $clog2(NUM_REQ),
  parameter int CNT_W       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_signed,
  input  logic [NUM_REQ*32-1:0] req_data,
  input  logic [NUM_REQ*3-1:0] req_rm,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [TAG_W-1:0]     resp_tag,
  output logic [32:0]          resp_out,
  output logic [4:0]           resp_flags,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_count
);

  localparam int LAST = PIPE_STAGES - 1;
  localparam logic [TAG_W:0] NREQ_W = (TAG_W+1)'(NUM_REQ);

  // stage valids, S0 = index 0, response stage = LAST
  logic [PIPE_STAGES-1:0] vld_q;
  logic [TAG_W-1:0]       tag_q   [PIPE_STAGES];
  logic [32:0]            out_q   [1:LAST];
  logic [4:0]             flags_q [1:LAST];
  logic                   s0_signed_q;
  logic [31:0]            s0_data_q;
  logic [2:0]             s0_rm_q;

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q;

  logic             adv, accept, win_found;
  logic [TAG_W-1:0] win_idx;
  logic [TAG_W:0]   j;
  logic [NUM_REQ-1:0] cand;
  logic             sel_signed;
  logic [31:0]      sel_data;
  logic [2:0]       sel_rm;

  // the whole pipe moves together; a stalled response freezes every stage
  assign adv = ~vld_q[LAST] | resp_ready;

  // round-robin search from ptr with wrap, then one-hot ready
  always_comb begin
    cand      = req_valid & {NUM_REQ{cfg_enable}};
    win_found = 1'b0;
    win_idx   = '0;
    j         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = {1'b0, ptr_q} + (TAG_W+1)'(k);
      if (j >= NREQ_W) j = j - NREQ_W;
      if (!win_found && cand[j[TAG_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = j[TAG_W-1:0];
      end
    end
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = reset & adv & win_found & (win_idx == TAG_W'(i));
    accept     = |req_ready;
    sel_signed = req_signed[win_idx];
    sel_data   = req_data[int'(win_idx)*32 +: 32];
    sel_rm     = req_rm[int'(win_idx)*3 +: 3];
    ptr_d      = ptr_q;
    if (accept) ptr_d = (win_idx == TAG_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
  end

  // conversion: magnitude, normalise, round to 24 bits, recode exponent
  logic        sgn, guard, sticky, inc;
  logic [31:0] absv, norm;
  logic [4:0]  lz;
  logic [24:0] sig;
  logic [8:0]  rexp;
  logic [22:0] frac;
  logic [32:0] cv_out;
  logic [4:0]  cv_flags;

  always_comb begin
    sgn  = s0_signed_q & s0_data_q[31];
    absv = sgn ? (32'd0 - s0_data_q) : s0_data_q;
    lz   = '0;
    for (int i = 0; i < 32; i++)
      if (absv[i]) lz = 5'(31 - i);
    norm   = absv << lz;
    guard  = norm[7];
    sticky = |norm[6:0];
    case (s0_rm_q)
      3'd1:    inc = 1'b0;                        // RTZ
      3'd2:    inc = sgn & (guard | sticky);      // RDN
      3'd3:    inc = ~sgn & (guard | sticky);     // RUP
      3'd4:    inc = guard;                       // RMM
      default: inc = guard & (sticky | norm[8]);  // RNE
    endcase
    sig  = {1'b0, norm[31:8]} + 25'(inc);
    // recoded exponent of 2^p is 0x100 + p; carry out of rounding bumps it
    rexp = 9'h100 + 9'(5'd31 - lz) + 9'(sig[24]);
    frac = sig[24] ? sig[23:1] : sig[22:0];
    cv_out   = (absv == 32'd0) ? 33'd0 : {sgn, rexp, frac};
    cv_flags = {4'b0, guard | sticky};
  end

  // control state: stage valids, RR pointer, completion counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (adv) vld_q <= {vld_q[PIPE_STAGES-2:0], accept};
      ptr_q <= ptr_d;
      if (vld_q[LAST] & resp_ready) cnt_q <= cnt_q + 1'b1;
    end
  end

  // payload registers need no reset; their valids qualify them
  always_ff @(posedge clock) begin
    if (adv) begin
      s0_signed_q <= sel_signed;
      s0_data_q   <= sel_data;
      s0_rm_q     <= sel_rm;
      tag_q[0]    <= win_idx;
      tag_q[1]    <= tag_q[0];
      out_q[1]    <= cv_out;
      flags_q[1]  <= cv_flags;
      for (int s = 2; s < PIPE_STAGES; s++) begin
        tag_q[s]   <= tag_q[s-1];
        out_q[s]   <= out_q[s-1];
        flags_q[s] <= flags_q[s-1];
      end
    end
  end

  assign resp_valid = vld_q[LAST];
  assign resp_tag   = tag_q[LAST];
  assign resp_out   = out_q[LAST];
  assign resp_flags = flags_q[LAST];
  assign busy       = |vld_q;
  assign done_count = cnt_q;

endmodule

// File: tb/tb_int_to_fp_convert_arbiter.sv
// Randomised + directed bench for int_to_fp_convert_arbiter against a
// cycle-level behavioural model (slot pipeline, RR pointer, arithmetic
// reference conversion using exact integer remainders).
module tb_int_to_fp_convert_arbiter;
  localparam int N  = 4;
  localparam int P  = 2;
  localparam int TW = 2;
  localparam int CW = 16;

  logic            clock = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_enable = 1'b1;
  logic [N-1:0]    req_valid = '1;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_signed = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N*3-1:0]  req_rm = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b1;
  logic [TW-1:0]   resp_tag;
  logic [32:0]     resp_out;
  logic [4:0]      resp_flags;
  logic            busy;
  logic [CW-1:0]   done_count;

  int_to_fp_convert_arbiter #(.NUM_REQ(N), .PIPE_STAGES(P), .TAG_W(TW), .CNT_W(CW)) dut (
    .clock(clock), .reset(rst_n), .cfg_enable(cfg_enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_data(req_data), .req_rm(req_rm),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
    .resp_out(resp_out), .resp_flags(resp_flags), .busy(busy), .done_count(done_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: round |x| to 24 significant bits by comparing the dropped
  // remainder against half an ulp; returns {flags, recoded}
  function automatic logic [37:0] ref_conv(input logic sg, input logic [31:0] d, input logic [2:0] rm);
    longint a, q, rem, half;
    int p;
    logic neg, up;
    neg = sg && d[31];
    a = neg ? (64'h1_0000_0000 - {32'b0, d}) : {32'b0, d};
    if (a == 0) return 38'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (a >= (64'sd1 << i)) p = i;
    if (p <= 23) begin q = a << (23 - p); rem = 0; half = 1; end
    else begin
      q = a >> (p - 23); rem = a - (q << (p - 23)); half = 64'sd1 << (p - 24);
    end
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = neg && rem != 0;
      3'd3:    up = !neg && rem != 0;
      3'd4:    up = rem >= half;
      default: up = (rem > half) || (rem == half && q[0]);
    endcase
    if (up) q++;
    if (q == (64'sd1 << 24)) begin q = 64'sd1 << 23; p++; end
    return {4'b0, rem != 0, neg, 9'(256 + p), q[22:0]};
  endfunction

  // model state
  logic          mv   [P];
  logic [TW-1:0] mtag [P];
  logic [32:0]   mout [P];
  logic [4:0]    mfl  [P];
  int            mptr;
  logic [CW-1:0] mdone;
  logic [N-1:0]  last_acc;

  function automatic logic mbusy();
    logic b = 1'b0;
    for (int s = 0; s < P; s++) b |= mv[s];
    return b;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < P; s++) mv[s] = 1'b0;
    mptr = 0; mdone = '0; last_acc = '0;
  endtask

  // one clock: called just after a negedge with inputs settled
  task automatic cycle();
    logic adv;
    logic [N-1:0] er;
    logic [37:0] r;
    int w;
    #1;
    adv = !mv[P-1] || resp_ready;
    er = '0; w = -1;
    if (adv && cfg_enable)
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(mptr + k) % N]) begin
          w = (mptr + k) % N; er[w] = 1'b1;
        end
    check("req_ready", req_ready, er);
    check("resp_valid", resp_valid, mv[P-1]);
    if (mv[P-1]) begin
      check("resp_tag", resp_tag, mtag[P-1]);
      check("resp_out", resp_out, mout[P-1]);
      check("resp_flags", resp_flags, mfl[P-1]);
    end
    check("busy", busy, mbusy());
    check("done_count", done_count, mdone);
    last_acc = er;
    if (mv[P-1] && resp_ready) mdone++;
    if (adv) begin
      for (int s = P - 1; s > 0; s--) begin
        mv[s] = mv[s-1]; mtag[s] = mtag[s-1]; mout[s] = mout[s-1]; mfl[s] = mfl[s-1];
      end
      mv[0] = (w >= 0);
      if (w >= 0) begin
        r = ref_conv(req_signed[w], req_data[32*w +: 32], req_rm[3*w +: 3]);
        mtag[0] = TW'(w); mout[0] = r[32:0]; mfl[0] = r[37:33];
        mptr = (w + 1) % N;
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_done_count", done_count, 0);
    model_clear();
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic send(input int idx, input logic sg, input logic [31:0] d, input logic [2:0] rm);
    logic got = 1'b0;
    req_valid[idx] = 1'b1; req_signed[idx] = sg;
    req_data[32*idx +: 32] = d; req_rm[3*idx +: 3] = rm;
    for (int c = 0; c < 20 && !got; c++) begin
      cycle();
      got = last_acc[idx];
    end
    if (!got) check("accept_timeout", 0, 1);
    req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && mbusy(); c++) cycle();
    if (mbusy()) check("drain_timeout", 1, 0);
  endtask

  task automatic rand_operands();
    logic [31:0] sv [7];
    sv[0] = 32'h0; sv[1] = 32'h1; sv[2] = 32'hFFFF_FFFF; sv[3] = 32'h8000_0000;
    sv[4] = 32'h7FFF_FFFF; sv[5] = 32'h0100_0001; sv[6] = 32'h00FF_FFFF;
    for (int i = 0; i < N; i++) begin
      req_data[32*i +: 32] = ($urandom % 4 == 0) ? sv[$urandom_range(0, 6)] : $urandom;
      req_signed[i] = 1'($urandom);
      req_rm[3*i +: 3] = 3'($urandom_range(0, 4));
    end
  endtask

  initial begin
    model_clear();
    do_reset();
    req_valid = '0;
    // directed vectors
    send(1, 1'b1, 32'hFFFF_FFFF, 3'd0);
    drain();
    send(0, 1'b0, 32'h0100_0001, 3'd0);
    send(0, 1'b0, 32'h0100_0001, 3'd3);
    drain();
    send(2, 1'b0, 32'h0, 3'd0);
    send(2, 1'b1, 32'h8000_0000, 3'd0);
    drain();
    // all requesters held valid
    rand_operands();
    req_valid = '1;
    repeat (6) cycle();
    req_valid = '0;
    drain();
    // full pipe then 3-cycle stall
    req_valid = '1;
    repeat (3) cycle();
    resp_ready = 1'b0;
    repeat (3) cycle();
    resp_ready = 1'b1;
    req_valid = '0;
    drain();
    // disable with requests in flight, then reset mid-stream
    req_valid = '1;
    repeat (2) cycle();
    cfg_enable = 1'b0;
    repeat (4) cycle();
    cfg_enable = 1'b1;
    repeat (2) cycle();
    do_reset();
    repeat (3) cycle();
    // random traffic
    for (int c = 0; c < 400; c++) begin
      rand_operands();
      req_valid  = N'($urandom);
      resp_ready = ($urandom % 4) != 0;
      cfg_enable = ($urandom % 8) != 0;
      cycle();
    end
    req_valid = '0; cfg_enable = 1'b1; resp_ready = 1'b1;
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
